// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: forward-select encodings,
// default register address width and scoreboard state encoding.
package hazard_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [0:0] {
        SB_IDLE = 1'b0,
        SB_BUSY = 1'b1
    } sb_state_t;

endpackage

// File: rtl/hazard_fwd_lane.sv
// Forwarding select for one execute-stage source operand.
// The memory stage wins over writeback, and x0 never forwards.
module hazard_fwd_lane
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output logic [1:0]            fwd
);

    logic rs_nonzero;

    assign rs_nonzero = (rs != '0);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m == rs) && rs_nonzero) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w == rs) && rs_nonzero) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: per-lane EX forwarding, load-use and scoreboard stalls,
// branch flushes, a single-entry multi-cycle scoreboard and a stall counter.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_SRC    = 2,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] Rs_D,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] Rs_E,
    input  logic [REG_ADDR_W-1:0]         RD_E,
    input  logic [REG_ADDR_W-1:0]         RD_M,
    input  logic [REG_ADDR_W-1:0]         RD_W,
    input  logic                          RegWriteE,
    input  logic                          RegWriteM,
    input  logic                          RegWriteW,
    input  logic                          LoadE,
    input  logic                          MultiCycE,
    input  logic                          MultiCycD,
    input  logic                          PCSrcE,
    output logic [2*NUM_SRC-1:0]          Forward_E,
    output logic                          StallF,
    output logic                          StallD,
    output logic                          FlushD,
    output logic                          FlushE,
    output logic                          mc_busy,
    output logic [REG_ADDR_W-1:0]         mc_rd,
    output logic                          mc_done,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int LAT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    sb_state_t               state, state_next;
    logic [LAT_W-1:0]        cnt, cnt_next;
    logic [REG_ADDR_W-1:0]   rd_next;
    logic                    done_next;
    logic [2*NUM_SRC-1:0]    fwd_raw;
    logic                    lw_stall, sb_stall, stall, stall_hold, issue;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        hazard_fwd_lane #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_lane (
            .rs          (Rs_E[i*REG_ADDR_W +: REG_ADDR_W]),
            .rd_m        (RD_M),
            .rd_w        (RD_W),
            .reg_write_m (RegWriteM),
            .reg_write_w (RegWriteW),
            .fwd         (fwd_raw[2*i +: 2])
        );
    end

    always_comb begin
        lw_stall = 1'b0;
        sb_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (LoadE && (RD_E != '0) && (RD_E == Rs_D[i*REG_ADDR_W +: REG_ADDR_W])) begin
                lw_stall = 1'b1;
            end
            if (mc_busy && (mc_rd != '0) && (mc_rd == Rs_D[i*REG_ADDR_W +: REG_ADDR_W])) begin
                sb_stall = 1'b1;
            end
        end
        if (mc_busy && MultiCycD) begin
            sb_stall = 1'b1;
        end
    end

    // A taken branch overrides a stall: the stalled D instruction is flushed anyway.
    assign stall      = rst & (lw_stall | sb_stall);
    assign stall_hold = stall & ~PCSrcE;
    assign Forward_E  = rst ? fwd_raw : '0;
    assign StallF     = stall_hold;
    assign StallD     = stall_hold;
    assign FlushD     = rst & PCSrcE;
    assign FlushE     = rst & (PCSrcE | stall);

    assign mc_busy = (state == SB_BUSY);
    assign issue   = MultiCycE & RegWriteE & ~mc_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SB_IDLE;
            cnt     <= '0;
            mc_rd   <= '0;
            mc_done <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            mc_rd   <= rd_next;
            mc_done <= done_next;
        end
    end

    // mc_done is registered one cycle early so it lines up with the count reaching zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rd_next    = mc_rd;
        done_next  = 1'b0;
        case (state)
            SB_IDLE: begin
                if (issue) begin
                    state_next = SB_BUSY;
                    cnt_next   = LAT_W'(MC_LAT - 1);
                    rd_next    = RD_E;
                end
            end
            SB_BUSY: begin
                if (cnt == '0) begin
                    state_next = SB_IDLE;
                end else begin
                    cnt_next  = cnt - LAT_W'(1);
                    done_next = (cnt == LAT_W'(1));
                end
            end
            default: state_next = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit with default parameters.
module tb_hazard_scoreboard_unit;

    logic        clk;
    logic        rst;
    logic [9:0]  Rs_D, Rs_E;
    logic [4:0]  RD_E, RD_M, RD_W;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        LoadE, MultiCycE, MultiCycD, PCSrcE;
    logic [3:0]  Forward_E;
    logic        StallF, StallD, FlushD, FlushE;
    logic        mc_busy;
    logic [4:0]  mc_rd;
    logic        mc_done;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard_unit dut (
        .clk       (clk),
        .rst       (rst),
        .Rs_D      (Rs_D),
        .Rs_E      (Rs_E),
        .RD_E      (RD_E),
        .RD_M      (RD_M),
        .RD_W      (RD_W),
        .RegWriteE (RegWriteE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .LoadE     (LoadE),
        .MultiCycE (MultiCycE),
        .MultiCycD (MultiCycD),
        .PCSrcE    (PCSrcE),
        .Forward_E (Forward_E),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .mc_busy   (mc_busy),
        .mc_rd     (mc_rd),
        .mc_done   (mc_done),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkControls(input string tag, input logic sf, input logic sd,
                                 input logic fd, input logic fe);
        checkOutput({tag, ".StallF"}, 32'(StallF), 32'(sf));
        checkOutput({tag, ".StallD"}, 32'(StallD), 32'(sd));
        checkOutput({tag, ".FlushD"}, 32'(FlushD), 32'(fd));
        checkOutput({tag, ".FlushE"}, 32'(FlushE), 32'(fe));
    endtask

    initial begin
        rst = 1'b0;
        Rs_D = '0; Rs_E = '0;
        RD_E = '0; RD_M = '0; RD_W = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        LoadE = 1'b0; MultiCycE = 1'b0; MultiCycD = 1'b0; PCSrcE = 1'b0;

        // Reset forces everything low even with a live forwarding match
        RegWriteM = 1'b1; RD_M = 5'd1; Rs_E = {5'd0, 5'd1};
        #2;
        checkOutput("rst.Forward_E", 32'(Forward_E), 32'h0);
        checkControls("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst.mc_busy", 32'(mc_busy), 32'h0);
        checkOutput("rst.mc_rd", 32'(mc_rd), 32'h0);
        checkOutput("rst.mc_done", 32'(mc_done), 32'h0);
        checkOutput("rst.stall_cnt", 32'(stall_cnt), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("fwd.lane0_mem", 32'(Forward_E), 32'b0010);
        tick();

        // Memory stage has priority over writeback
        RD_M = 5'd3; RD_W = 5'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
        Rs_E = {5'd3, 5'd0};
        #1;
        checkOutput("fwd.lane1_mpri", 32'(Forward_E), 32'b1000);
        RegWriteM = 1'b0;
        #1;
        checkOutput("fwd.lane1_wb", 32'(Forward_E), 32'b0100);
        RegWriteM = 1'b1; RD_M = 5'd0; RD_W = 5'd0; Rs_E = '0;
        #1;
        checkOutput("fwd.x0", 32'(Forward_E), 32'b0000);
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        tick();

        // Load to x0 never stalls
        LoadE = 1'b1; RD_E = 5'd0; Rs_D = '0;
        #1;
        checkControls("lw.x0", 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use on lane 1
        RD_E = 5'd5; Rs_D = {5'd5, 5'd0};
        #1;
        checkControls("lw.use", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("lw.cnt0", 32'(stall_cnt), 32'd0);
        tick();
        checkOutput("lw.cnt1", 32'(stall_cnt), 32'd1);
        PCSrcE = 1'b1;
        #1;
        checkControls("lw.branch", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("lw.cnt_hold", 32'(stall_cnt), 32'd1);
        PCSrcE = 1'b0; LoadE = 1'b0; RD_E = '0; Rs_D = '0;

        // Multi-cycle issue to x7, dependent instruction in D
        MultiCycE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7;
        #1;
        checkOutput("mc.pre_busy", 32'(mc_busy), 32'h0);
        tick();
        MultiCycE = 1'b0; RegWriteE = 1'b0; RD_E = '0;
        Rs_D = {5'd0, 5'd7};
        #1;
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("mc.busy_c%0d", c), 32'(mc_busy), 32'h1);
            checkOutput($sformatf("mc.rd_c%0d", c), 32'(mc_rd), 32'd7);
            checkOutput($sformatf("mc.done_c%0d", c), 32'(mc_done), 32'(c == 4));
            checkOutput($sformatf("mc.stall_c%0d", c), 32'(StallD), 32'h1);
            checkOutput($sformatf("mc.cnt_c%0d", c), 32'(stall_cnt), 32'(1 + c - 1));
            if (c < 4) tick();
        end
        tick();
        checkOutput("mc.release_busy", 32'(mc_busy), 32'h0);
        checkOutput("mc.release_done", 32'(mc_done), 32'h0);
        checkOutput("mc.release_stall", 32'(StallD), 32'h0);
        checkOutput("mc.release_cnt", 32'(stall_cnt), 32'd5);

        // Structural stall; a second issue while busy is ignored
        Rs_D = {5'd4, 5'd2};
        MultiCycE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd9;
        tick();
        RD_E = 5'd12;
        #1;
        checkOutput("st.no_dep", 32'(StallD), 32'h0);
        MultiCycD = 1'b1;
        #1;
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("st.stall_c%0d", c), 32'(StallD), 32'h1);
            checkOutput($sformatf("st.rd_c%0d", c), 32'(mc_rd), 32'd9);
            checkOutput($sformatf("st.done_c%0d", c), 32'(mc_done), 32'(c == 4));
            checkOutput($sformatf("st.cnt_c%0d", c), 32'(stall_cnt), 32'(5 + c - 1));
            if (c < 4) tick();
        end
        tick();
        checkOutput("st.release_busy", 32'(mc_busy), 32'h0);
        checkOutput("st.release_stall", 32'(StallD), 32'h0);
        checkOutput("st.release_cnt", 32'(stall_cnt), 32'd9);
        MultiCycD = 1'b0;

        // Fresh issue to x12, then reset in the middle of it
        tick();
        MultiCycE = 1'b0; RegWriteE = 1'b0; RD_E = '0;
        checkOutput("ab.busy", 32'(mc_busy), 32'h1);
        checkOutput("ab.rd", 32'(mc_rd), 32'd12);
        Rs_D = {5'd0, 5'd12};
        tick();
        checkOutput("ab.cnt", 32'(stall_cnt), 32'd10);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("ab.async_busy", 32'(mc_busy), 32'h0);
        checkOutput("ab.async_done", 32'(mc_done), 32'h0);
        checkOutput("ab.async_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("ab.async_stall", 32'(StallD), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        Rs_D = {5'd0, 5'd7};
        #1;
        checkOutput("ab.post_busy", 32'(mc_busy), 32'h0);
        checkControls("ab.post", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ab.post_cnt", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
